// File: rtl/controller_ports.sv
// NES controller ports at $4016/$4017: strobe latch plus serial pad shift registers.
// Pad 2 is built only when CONTROLLER_PORTS_P2_EN is defined; otherwise $4017 reads return 8'h40.
module controller_ports (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_data_en,
  input  logic [7:0]  i_buttons_p1,
  input  logic [7:0]  i_buttons_p2
);

  logic sel4016, sel4017;
  logic rd4016, rd4017, wr4016;

  assign sel4016 = (i_address == 16'h4016);
  assign sel4017 = (i_address == 16'h4017);
  assign rd4016  = i_ce &  i_rw & sel4016;
  assign rd4017  = i_ce &  i_rw & sel4017;
  assign wr4016  = i_ce & ~i_rw & sel4016;

  logic       strobe_q, strobe_d;
  logic [7:0] sr1_q, sr1_d;
  logic [3:0] cnt1_q, cnt1_d;

  // Reload is keyed on the registered strobe, so a write clearing it still reloads once.
  always_comb begin
    strobe_d = strobe_q;
    if (wr4016) begin
      strobe_d = i_data[0];
    end
  end

  always_comb begin
    sr1_d  = sr1_q;
    cnt1_d = cnt1_q;
    if (strobe_q) begin
      sr1_d  = i_buttons_p1;
      cnt1_d = 4'd0;
    end else if (rd4016) begin
      sr1_d  = {1'b1, sr1_q[7:1]};
      cnt1_d = (cnt1_q >= 4'd8) ? 4'd8 : cnt1_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      strobe_q <= 1'b0;
      sr1_q    <= 8'hFF;
      cnt1_q   <= 4'd8;
    end else begin
      strobe_q <= strobe_d;
      sr1_q    <= sr1_d;
      cnt1_q   <= cnt1_d;
    end
  end

`ifdef CONTROLLER_PORTS_P2_EN
  logic [7:0] sr2_q, sr2_d;
  logic [3:0] cnt2_q, cnt2_d;

  always_comb begin
    sr2_d  = sr2_q;
    cnt2_d = cnt2_q;
    if (strobe_q) begin
      sr2_d  = i_buttons_p2;
      cnt2_d = 4'd0;
    end else if (rd4017) begin
      sr2_d  = {1'b1, sr2_q[7:1]};
      cnt2_d = (cnt2_q >= 4'd8) ? 4'd8 : cnt2_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sr2_q  <= 8'hFF;
      cnt2_q <= 4'd8;
    end else begin
      sr2_q  <= sr2_d;
      cnt2_q <= cnt2_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{i_data[7:1]};
`else
  logic unused_ok;
  assign unused_ok = ^{i_data[7:1], i_buttons_p2};
`endif

  // Upper bits model open-bus high byte of the address ($40) seen on real hardware.
  always_comb begin
    o_data    = 8'h00;
    o_data_en = 1'b0;
    if (rd4016) begin
      o_data_en = 1'b1;
      o_data    = {7'b0100000, strobe_q ? i_buttons_p1[0] : sr1_q[0]};
    end else if (rd4017) begin
      o_data_en = 1'b1;
`ifdef CONTROLLER_PORTS_P2_EN
      o_data    = {7'b0100000, strobe_q ? i_buttons_p2[0] : sr2_q[0]};
`else
      o_data    = 8'h40;
`endif
    end
  end

endmodule

// File: tb/tb_controller_ports.sv
// Directed bench for controller_ports; pad-2 checks follow CONTROLLER_PORTS_P2_EN.
module tb_controller_ports;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_ce = 1'b0;
  logic [15:0] i_address = 16'h0000;
  logic        i_rw = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic [7:0]  o_data;
  logic        o_data_en;
  logic [7:0]  i_buttons_p1 = 8'h00;
  logic [7:0]  i_buttons_p2 = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  controller_ports dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ce         (i_ce),
    .i_address    (i_address),
    .i_rw         (i_rw),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_data_en    (o_data_en),
    .i_buttons_p1 (i_buttons_p1),
    .i_buttons_p2 (i_buttons_p2)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] exp_data, input logic exp_en);
    n_cmp++;
    assert (o_data === exp_data) else begin
      n_bad++;
      $error("FAIL %s: o_data=%h expected %h", tag, o_data, exp_data);
    end
    n_cmp++;
    assert (o_data_en === exp_en) else begin
      n_bad++;
      $error("FAIL %s: o_data_en=%b expected %b", tag, o_data_en, exp_en);
    end
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, let the edge pass.
  task automatic bus(input string tag, input logic ce, input logic rw, input logic [15:0] addr,
                     input logic [7:0] wdat, input logic [7:0] exp_data, input logic exp_en);
    @(negedge i_clk);
    i_ce = ce; i_rw = rw; i_address = addr; i_data = wdat;
    #1 check(tag, exp_data, exp_en);
    @(posedge i_clk);
    #1 i_ce = 1'b0; i_rw = 1'b1; i_address = 16'h0000; i_data = 8'h00;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp_data);
    bus(tag, 1'b1, 1'b1, addr, 8'h00, exp_data, 1'b1);
  endtask

  task automatic wr(input string tag, input logic [15:0] addr, input logic [7:0] wdat);
    bus(tag, 1'b1, 1'b0, addr, wdat, 8'h00, 1'b0);
  endtask

  task automatic strobe_cycle();
    wr("strobe_hi", 16'h4016, 8'h01);
    wr("strobe_lo", 16'h4016, 8'hFE);
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'b1010_0101;

    // Reset state
    #2 check("reset_idle", 8'h00, 1'b0);
    @(negedge i_clk); @(negedge i_clk);
    i_reset = 1'b0;

    // Reads after reset return $41 and only drive during i_ce
    rd("rst_rd0", 16'h4016, 8'h41);
    bus("rst_noce", 1'b0, 1'b1, 16'h4016, 8'h00, 8'h00, 1'b0);
    rd("rst_rd1", 16'h4016, 8'h41);
    rd("rst_rd2", 16'h4016, 8'h41);

    // Report A5 serialised LSB first, then ones; an i_ce-less cycle mid-report has no effect
    i_buttons_p1 = a5;
    strobe_cycle();
    rd("a5_b0", 16'h4016, 8'h41);
    rd("a5_b1", 16'h4016, 8'h40);
    bus("a5_noce", 1'b0, 1'b1, 16'h4016, 8'h00, 8'h00, 1'b0);
    rd("a5_b2", 16'h4016, 8'h41);
    rd("a5_b3", 16'h4016, 8'h40);
    rd("a5_b4", 16'h4016, 8'h40);
    rd("a5_b5", 16'h4016, 8'h41);
    rd("a5_b6", 16'h4016, 8'h40);
    rd("a5_b7", 16'h4016, 8'h41);
    rd("a5_sat8", 16'h4016, 8'h41);
    rd("a5_sat9", 16'h4016, 8'h41);

    // Strobe held: reads follow the live A bit; release latches the value at release
    wr("hold_hi", 16'h4016, 8'h01);
    i_buttons_p1 = 8'h01; rd("live_a1", 16'h4016, 8'h41);
    i_buttons_p1 = 8'h00; rd("live_a0", 16'h4016, 8'h40);
    i_buttons_p1 = 8'hFF; rd("live_ff", 16'h4016, 8'h41);
    i_buttons_p1 = 8'h00; rd("live_00", 16'h4016, 8'h40);
    wr("hold_lo", 16'h4016, 8'h00);
    i_buttons_p1 = 8'hFF;
    rd("rel_b0", 16'h4016, 8'h40);
    rd("rel_b1", 16'h4016, 8'h40);

    // Asynchronous reset mid-report discards the partial report
    i_buttons_p1 = a5;
    strobe_cycle();
    rd("pre_b0", 16'h4016, 8'h41);
    rd("pre_b1", 16'h4016, 8'h40);
    rd("pre_b2", 16'h4016, 8'h41);
    @(negedge i_clk);
    i_reset = 1'b1;
    i_ce = 1'b1; i_rw = 1'b1; i_address = 16'h4016;
    #1 check("in_reset", 8'h41, 1'b1);
    @(posedge i_clk);
    #1 i_ce = 1'b0; i_address = 16'h0000;
    @(negedge i_clk);
    i_reset = 1'b0;
    rd("post_rst0", 16'h4016, 8'h41);
    rd("post_rst1", 16'h4016, 8'h41);

    // Undecoded accesses: no drive, no shift, $4017 write does not touch strobe
    i_buttons_p1 = a5;
    strobe_cycle();
    i_buttons_p1 = 8'hFF;
    bus("rd_4015", 1'b1, 1'b1, 16'h4015, 8'h00, 8'h00, 1'b0);
    bus("rd_4018", 1'b1, 1'b1, 16'h4018, 8'h00, 8'h00, 1'b0);
    bus("rd_c016", 1'b1, 1'b1, 16'hC016, 8'h00, 8'h00, 1'b0);
    wr("wr_4017", 16'h4017, 8'h01);
    rd("undec_b0", 16'h4016, 8'h41);
    rd("undec_b1", 16'h4016, 8'h40);
    rd("undec_b2", 16'h4016, 8'h41);

`ifdef CONTROLLER_PORTS_P2_EN
    // Interleaved ports advance independently
    i_buttons_p1 = 8'h01; i_buttons_p2 = 8'h80;
    strobe_cycle();
    i_buttons_p1 = 8'h00; i_buttons_p2 = 8'h00;
    rd("il_p1_b0", 16'h4016, 8'h41);
    rd("il_p2_b0", 16'h4017, 8'h40);
    rd("il_p1_b1", 16'h4016, 8'h40);
    for (int i = 1; i < 7; i++) rd("il_p2_mid", 16'h4017, 8'h40);
    rd("il_p2_b7", 16'h4017, 8'h41);
    rd("il_p1_b2", 16'h4016, 8'h40);
    rd("il_p2_sat", 16'h4017, 8'h41);
    i_buttons_p2 = 8'hFF;
    strobe_cycle();
    rd("p2_ff_0", 16'h4017, 8'h41);
    rd("p2_ff_1", 16'h4017, 8'h41);
    rd("p2_ff_2", 16'h4017, 8'h41);
`else
    // No pad 2: $4017 reports nothing connected, $4016 unaffected
    i_buttons_p1 = a5; i_buttons_p2 = 8'hFF;
    strobe_cycle();
    rd("nop2_0", 16'h4017, 8'h40);
    rd("nop2_1", 16'h4017, 8'h40);
    rd("nop2_2", 16'h4017, 8'h40);
    rd("nop2_p1_b0", 16'h4016, 8'h41);
    rd("nop2_p1_b1", 16'h4016, 8'h40);
    rd("nop2_p1_b2", 16'h4016, 8'h41);
    rd("nop2_p1_b3", 16'h4016, 8'h40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
